// File: rtl/cpu_pkg.sv
// Shared stack-CPU definitions: instruction phase encoding and parameter limits.
package cpu_pkg;

    typedef enum logic [1:0] {
        PH_FETCH  = 2'd0,
        PH_DECODE = 2'd1,
        PH_EXEC   = 2'd2,
        PH_RDMEM  = 2'd3
    } phase_t;

    localparam int NIRQ_MAX     = 16;
    localparam int MEM_WAIT_MAX = 7;

    // Width of an index into n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index-wins priority encoder for interrupt requests.
module irq_prio_enc
    import cpu_pkg::*;
#(
    parameter  int NIRQ  = 4,
    localparam int VEC_W = idx_width(NIRQ)
) (
    input  logic [NIRQ-1:0]  req,
    output logic             any,
    output logic [VEC_W-1:0] idx
);

    // Scan from the top down so the lowest set index is written last.
    always_comb begin
        any = |req;
        idx = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = VEC_W'(i);
            end
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// Instruction-phase sequencer with memory wait insertion, bus stall and interrupt latch.
module phase_sequencer
    import cpu_pkg::*;
#(
    parameter  int NIRQ     = 4,
    parameter  int MEM_WAIT = 0,
    localparam int VEC_W    = idx_width(NIRQ),
    localparam int WAIT_W   = idx_width(MEM_WAIT + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NIRQ-1:0]   irq,
    input  logic [NIRQ-1:0]   irq_mask,
    input  logic              ien,
    input  logic              insn_rd,
    input  logic              stall,
    output logic              phase_fetch,
    output logic              phase_decode,
    output logic              phase_exec,
    output logic              phase_rdmem,
    output logic              phase_half,
    output logic              irq_pend,
    output logic [VEC_W-1:0]  irq_vec,
    output logic              irq_taken,
    output phase_t            dbg_phase,
    output logic [WAIT_W-1:0] dbg_wait_cnt
);

    if (NIRQ < 1 || NIRQ > NIRQ_MAX) begin : g_bad_nirq
        $error("phase_sequencer: NIRQ must be in 1..16");
    end
    if (MEM_WAIT < 0 || MEM_WAIT > MEM_WAIT_MAX) begin : g_bad_mem_wait
        $error("phase_sequencer: MEM_WAIT must be in 0..7");
    end

    phase_t             phase_q, phase_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               pend_q, pend_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic               taken_q, taken_d;

    logic [NIRQ-1:0]    req;
    logic               req_any;
    logic [VEC_W-1:0]   req_idx;

    assign req = irq & irq_mask & {NIRQ{ien}};

    irq_prio_enc #(
        .NIRQ (NIRQ)
    ) u_prio (
        .req (req),
        .any (req_any),
        .idx (req_idx)
    );

    // stall is a pure hold: while high nothing advances and irq_taken drops.
    always_comb begin
        phase_d = phase_q;
        wait_d  = wait_q;
        pend_d  = pend_q;
        vec_d   = vec_q;
        taken_d = 1'b0;
        if (!stall) begin
            unique case (phase_q)
                PH_FETCH: begin
                    phase_d = PH_DECODE;
                    pend_d  = req_any;
                    vec_d   = req_idx;
                end
                PH_DECODE: begin
                    phase_d = PH_EXEC;
                end
                PH_EXEC: begin
                    taken_d = pend_q;
                    // An interrupted slot is a vector jump, so it never reads memory.
                    if (insn_rd && !pend_q) begin
                        phase_d = PH_RDMEM;
                        wait_d  = '0;
                    end else begin
                        phase_d = PH_FETCH;
                    end
                end
                PH_RDMEM: begin
                    if (wait_q == WAIT_W'(MEM_WAIT)) begin
                        phase_d = PH_FETCH;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
                default: begin
                    phase_d = PH_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_FETCH;
            wait_q  <= '0;
            pend_q  <= 1'b0;
            vec_q   <= '0;
            taken_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            wait_q  <= wait_d;
            pend_q  <= pend_d;
            vec_q   <= vec_d;
            taken_q <= taken_d;
        end
    end

    assign phase_fetch  = (phase_q == PH_FETCH);
    assign phase_decode = (phase_q == PH_DECODE);
    assign phase_exec   = (phase_q == PH_EXEC);
    assign phase_rdmem  = (phase_q == PH_RDMEM);
    assign phase_half   = phase_decode | phase_exec;
    assign irq_pend     = pend_q;
    assign irq_vec      = vec_q;
    assign irq_taken    = taken_q;
    assign dbg_phase    = phase_q;
    assign dbg_wait_cnt = wait_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: instruction-level reference model with randomized stalls and requests.
module tb_phase_sequencer;
    import cpu_pkg::*;

    localparam int NIRQ     = 4;
    localparam int MEM_WAIT = 2;
    localparam int VEC_W    = 2;
    localparam int WAIT_W   = 2;
    localparam int OW       = 11;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [NIRQ-1:0]   irq = '0;
    logic [NIRQ-1:0]   irq_mask = '0;
    logic              ien = 1'b0;
    logic              insn_rd = 1'b0;
    logic              stall = 1'b1;
    logic              phase_fetch, phase_decode, phase_exec, phase_rdmem, phase_half;
    logic              irq_pend, irq_taken;
    logic [VEC_W-1:0]  irq_vec;
    phase_t            dbg_phase;
    logic [WAIT_W-1:0] dbg_wait_cnt;

    int checks = 0;
    int fails  = 0;

    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] obs_q[$];

    // Model state carried between instructions.
    bit          m_pend  = 1'b0;
    logic [1:0]  m_vec   = '0;
    bit          m_taken = 1'b0;
    logic [1:0]  m_wait  = '0;

    phase_sequencer #(
        .NIRQ     (NIRQ),
        .MEM_WAIT (MEM_WAIT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq          (irq),
        .irq_mask     (irq_mask),
        .ien          (ien),
        .insn_rd      (insn_rd),
        .stall        (stall),
        .phase_fetch  (phase_fetch),
        .phase_decode (phase_decode),
        .phase_exec   (phase_exec),
        .phase_rdmem  (phase_rdmem),
        .phase_half   (phase_half),
        .irq_pend     (irq_pend),
        .irq_vec      (irq_vec),
        .irq_taken    (irq_taken),
        .dbg_phase    (dbg_phase),
        .dbg_wait_cnt (dbg_wait_cnt)
    );

    always #5 clk = ~clk;

    // ph: 0 fetch, 1 decode, 2 exec, 3 rdmem
    function automatic logic [OW-1:0] pack(input int ph, input bit pend, input logic [1:0] vec,
                                           input bit taken, input logic [1:0] w);
        logic [3:0] oh;
        oh = 4'b0001 << ph;
        return {oh[0], oh[1], oh[2], oh[3], oh[1] | oh[2], pend, vec, taken, w};
    endfunction

    function automatic logic [OW-1:0] observe();
        return {phase_fetch, phase_decode, phase_exec, phase_rdmem, phase_half,
                irq_pend, irq_vec, irq_taken, dbg_wait_cnt};
    endfunction

    // Drives one instruction starting in its first FETCH cycle (time = posedge + 1).
    task automatic drive_insn(input bit rd, input logic [3:0] irq_v, input logic [3:0] mask_v,
                              input bit ien_v, input int stall_step, input int stall_n,
                              input int rand_stall);
        logic [3:0] req;
        bit         pend;
        logic [1:0] vec;
        int         steps[$];
        int         ns;
        int         ph;
        bit         st;
        bit         e_pend;
        logic [1:0] e_vec;
        bit         e_taken;
        logic [1:0] e_wait;
        req  = irq_v & mask_v & {4{ien_v}};
        pend = 1'b0;
        vec  = '0;
        for (int i = 0; i < NIRQ; i++) begin
            if (req[i] && !pend) begin
                pend = 1'b1;
                vec  = 2'(i);
            end
        end
        steps = '{0, 1, 2};
        if (rd && !pend) begin
            for (int k = 0; k <= MEM_WAIT; k++) steps.push_back(3);
        end
        for (int j = 0; j < steps.size(); j++) begin
            ns = (j == stall_step) ? stall_n : int'($urandom_range(0, rand_stall));
            ph = steps[j];
            for (int c = 0; c <= ns; c++) begin
                st      = (c < ns);
                e_pend  = (j == 0) ? m_pend : pend;
                e_vec   = (j == 0) ? m_vec : vec;
                e_taken = (j == 0 && c == 0) ? m_taken : 1'b0;
                e_wait  = (ph == 3) ? 2'(j - 3) : m_wait;
                exp_q.push_back(pack(ph, e_pend, e_vec, e_taken, e_wait));
                obs_q.push_back(observe());
                stall = st;
                if (ph == 0 && !st) begin
                    irq      = irq_v;
                    irq_mask = mask_v;
                    ien      = ien_v;
                end else begin
                    irq      = 4'($urandom);
                    irq_mask = 4'($urandom);
                    ien      = 1'($urandom);
                end
                insn_rd = (ph == 2 && !st) ? rd : 1'($urandom);
                @(posedge clk);
                #1;
            end
            if (ph == 3) m_wait = 2'(j - 3);
        end
        stall   = 1'b0;
        m_pend  = pend;
        m_vec   = vec;
        m_taken = pend;
    endtask

    task automatic test_reset();
        logic [OW-1:0] o;
        stall = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        o = observe();
        checks++;
        if (o !== pack(0, 0, 0, 0, 0)) begin
            fails++;
            $display("FAIL reset_async: observed %b expected %b", o, pack(0, 0, 0, 0, 0));
        end
        checks++;
        if (dbg_phase !== PH_FETCH) begin
            fails++;
            $display("FAIL reset_phase: observed %0d expected %0d", dbg_phase, PH_FETCH);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        o = observe();
        checks++;
        if (o !== pack(0, 0, 0, 0, 0)) begin
            fails++;
            $display("FAIL reset_release: observed %b expected %b", o, pack(0, 0, 0, 0, 0));
        end
        stall = 1'b0;
    endtask

    task automatic test_plain();
        logic [OW-1:0] e, o;
        repeat (4) drive_insn(1'b0, 4'b0000, 4'b1111, 1'b1, -1, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                fails++;
                $display("FAIL plain: observed %b expected %b", o, e);
            end
        end
    endtask

    task automatic test_read();
        logic [OW-1:0] e, o;
        drive_insn(1'b1, 4'b0000, 4'b1111, 1'b1, -1, 0, 0);
        drive_insn(1'b0, 4'b0000, 4'b1111, 1'b0, -1, 0, 0);
        drive_insn(1'b1, 4'b1111, 4'b1111, 1'b0, -1, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                fails++;
                $display("FAIL read: observed %b expected %b", o, e);
            end
        end
    endtask

    task automatic test_irq_priority();
        logic [OW-1:0] e, o;
        drive_insn(1'b1, 4'b1010, 4'b1111, 1'b1, -1, 0, 0);
        drive_insn(1'b0, 4'b1100, 4'b1111, 1'b1, -1, 0, 0);
        drive_insn(1'b0, 4'b0000, 4'b1111, 1'b1, -1, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                fails++;
                $display("FAIL irq_priority: observed %b expected %b", o, e);
            end
        end
    endtask

    task automatic test_mask_ien();
        logic [OW-1:0] e, o;
        drive_insn(1'b0, 4'b0100, 4'b1011, 1'b1, -1, 0, 0);
        drive_insn(1'b1, 4'b0100, 4'b1111, 1'b0, -1, 0, 0);
        drive_insn(1'b1, 4'b0100, 4'b1111, 1'b1, -1, 0, 0);
        drive_insn(1'b0, 4'b0000, 4'b0000, 1'b1, -1, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                fails++;
                $display("FAIL mask_ien: observed %b expected %b", o, e);
            end
        end
    endtask

    task automatic test_stall();
        logic [OW-1:0] e, o;
        drive_insn(1'b1, 4'b0000, 4'b1111, 1'b1, 4, 2, 0);
        drive_insn(1'b0, 4'b0001, 4'b1111, 1'b1, 0, 2, 0);
        drive_insn(1'b1, 4'b1000, 4'b1000, 1'b1, 2, 3, 0);
        drive_insn(1'b1, 4'b0000, 4'b1111, 1'b1, 0, 2, 0);
        drive_insn(1'b0, 4'b0000, 4'b1111, 1'b1, 1, 1, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                fails++;
                $display("FAIL stall: observed %b expected %b", o, e);
            end
        end
    endtask

    task automatic test_reset_mid_rdmem();
        logic [OW-1:0] e, o;
        stall   = 1'b0;
        ien     = 1'b0;
        irq     = '0;
        insn_rd = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        o = observe();
        checks++;
        if (o !== pack(3, 0, 0, 0, 1)) begin
            fails++;
            $display("FAIL rdmem_before_reset: observed %b expected %b", o, pack(3, 0, 0, 0, 1));
        end
        #2 rst_n = 1'b0;
        #1;
        o = observe();
        checks++;
        if (o !== pack(0, 0, 0, 0, 0)) begin
            fails++;
            $display("FAIL reset_in_rdmem: observed %b expected %b", o, pack(0, 0, 0, 0, 0));
        end
        stall = 1'b1;
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        stall   = 1'b0;
        m_pend  = 1'b0;
        m_vec   = '0;
        m_taken = 1'b0;
        m_wait  = '0;
        drive_insn(1'b0, 4'b0000, 4'b1111, 1'b1, -1, 0, 0);
        drive_insn(1'b1, 4'b0000, 4'b1111, 1'b1, -1, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                fails++;
                $display("FAIL after_reset: observed %b expected %b", o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [OW-1:0] e, o;
        for (int n = 0; n < 60; n++) begin
            drive_insn(1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), -1, 0, 2);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                fails++;
                $display("FAIL back_to_back: observed %b expected %b", o, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_plain();
        test_read();
        test_irq_priority();
        test_mask_ien();
        test_stall();
        test_reset_mid_rdmem();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
